// File: rtl/mtime_bus_master.sv
// mtime_bus_master
// Command-driven bus initiator for the machine-timer register block
// (mtime at 0x0/0x4, mtimecmp at 0x8/0xC). One 64-bit command becomes the
// race-free 32-bit access sequence:
//   read           : hi, lo, hi again; retry lo/hi while the two hi words differ
//   write mtimecmp : lo = all-ones, hi, lo
//   write mtime    : lo = zero,     hi, lo
//
// Ports
//   clk_i, reset_i   clock, asynchronous active-low reset
//   req_i            command request, accepted only while idle
//   op_i             00 rd mtime, 01 wr mtimecmp, 10 wr mtime, 11 rd mtimecmp
//   wdata_i          64-bit write value, sampled at acceptance
//   busy_o           high whenever a command is in progress (incl. DONE)
//   done_o, err_o    one-cycle completion pulse; err_o = retry limit exceeded
//   rdata_o          last successful read result
//   csb_o, wen_o     peripheral chip select / write enable, both active low
//   addr_o, wmask_o  byte address and byte mask of the current access
//   data_o, data_i   write data out, combinational read data in
module mtime_bus_master #(
  parameter int RETRY_MAX = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic [1:0]  op_i,
  input  logic [63:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [63:0] rdata_o,
  output logic        csb_o,
  output logic        wen_o,
  output logic [3:0]  addr_o,
  output logic [3:0]  wmask_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i
);

  // One spare bit so the counter can never wrap before the limit compare.
  localparam int RW = $clog2(RETRY_MAX + 1) + 1;

  typedef enum logic [2:0] {
    IDLE, RD_HI1, RD_LO, RD_HI2, WR_LO0, WR_HI, WR_LO, DONE
  } state_t;

  state_t        state_q, state_d;
  logic          cmp_q;
  logic [63:0]   wdata_q;
  logic [31:0]   hi1_q, lo_q;
  logic [RW-1:0] retry_q;
  logic [63:0]   rdata_q;
  logic          err_q;

  logic          hi_match;
  logic          retry_exhausted;
  logic          req_is_read;
  logic [3:0]    addr_lo, addr_hi;

  // op 00/11 are reads; op bit 0 selects the mtimecmp pair (base 0x8).
  assign req_is_read     = (op_i == 2'b00) || (op_i == 2'b11);
  assign addr_lo         = {cmp_q, 1'b0, 2'b00};
  assign addr_hi         = {cmp_q, 1'b1, 2'b00};
  assign hi_match        = (data_i == hi1_q);
  // Another mismatch would push the retry count past RETRY_MAX.
  assign retry_exhausted = (retry_q >= RW'(RETRY_MAX));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    csb_o   = 1'b1;
    wen_o   = 1'b1;
    addr_o  = 4'h0;
    wmask_o = 4'h0;
    data_o  = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_i) state_d = req_is_read ? RD_HI1 : WR_LO0;
      end
      RD_HI1: begin
        csb_o   = 1'b0;
        addr_o  = addr_hi;
        state_d = RD_LO;
      end
      RD_LO: begin
        csb_o   = 1'b0;
        addr_o  = addr_lo;
        state_d = RD_HI2;
      end
      RD_HI2: begin
        csb_o  = 1'b0;
        addr_o = addr_hi;
        if (hi_match || retry_exhausted) state_d = DONE;
        else                             state_d = RD_LO;
      end
      WR_LO0: begin
        // Parks the low word where the partial 64-bit value can neither fire
        // a spurious compare (mtimecmp) nor carry into hi (mtime).
        csb_o   = 1'b0;
        wen_o   = 1'b0;
        wmask_o = 4'hF;
        addr_o  = addr_lo;
        data_o  = cmp_q ? 32'hFFFF_FFFF : 32'h0000_0000;
        state_d = WR_HI;
      end
      WR_HI: begin
        csb_o   = 1'b0;
        wen_o   = 1'b0;
        wmask_o = 4'hF;
        addr_o  = addr_hi;
        data_o  = wdata_q[63:32];
        state_d = WR_LO;
      end
      WR_LO: begin
        csb_o   = 1'b0;
        wen_o   = 1'b0;
        wmask_o = 4'hF;
        addr_o  = addr_lo;
        data_o  = wdata_q[31:0];
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, read capture and retry bookkeeping. Read data is taken at
  // the edge that ends each access cycle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cmp_q   <= 1'b0;
      wdata_q <= 64'h0;
      hi1_q   <= 32'h0;
      lo_q    <= 32'h0;
      retry_q <= '0;
      rdata_q <= 64'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            cmp_q   <= op_i[0];
            wdata_q <= wdata_i;
            retry_q <= '0;
          end
        end
        RD_HI1: hi1_q <= data_i;
        RD_LO:  lo_q  <= data_i;
        RD_HI2: begin
          if (hi_match) begin
            rdata_q <= {hi1_q, lo_q};
          end else if (retry_exhausted) begin
            err_q <= 1'b1;
          end else begin
            hi1_q   <= data_i;
            retry_q <= retry_q + RW'(1);
          end
        end
        DONE:    err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mtime_bus_master.sv
// Testbench for mtime_bus_master: a small timer-peripheral model answers the
// bus; stimulus pushes the expected bus trace and completion into queues and
// an independent monitor pops and compares them on every falling edge.
module tb_mtime_bus_master;

  localparam int RETRY_MAX = 3;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        req_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [63:0] wdata_i = 64'h0;
  logic        busy_o, done_o, err_o;
  logic [63:0] rdata_o;
  logic        csb_o, wen_o;
  logic [3:0]  addr_o, wmask_o;
  logic [31:0] data_o;
  logic [31:0] data_i;

  mtime_bus_master #(.RETRY_MAX(RETRY_MAX)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req_i   (req_i),
    .op_i    (op_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .rdata_o (rdata_o),
    .csb_o   (csb_o),
    .wen_o   (wen_o),
    .addr_o  (addr_o),
    .wmask_o (wmask_o),
    .data_o  (data_o),
    .data_i  (data_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Timer peripheral model: mtime counts every cycle unless written that cycle.
  // In noise mode every hi-word read returns a fresh value.
  logic [63:0] mtime = 64'h0;
  logic [63:0] mtimecmp = '1;
  logic        noise_en = 1'b0;
  logic [31:0] noise_cnt = 32'h0;
  logic        mtip;

  assign mtip = (mtime >= mtimecmp);

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old_w & ~bm) | (new_w & bm);
  endfunction

  always_comb begin
    data_i = 32'h0;
    if (!csb_o && wen_o) begin
      case (addr_o)
        4'h0: data_i = mtime[31:0];
        4'h4: data_i = noise_en ? 32'hA5A5_0000 + noise_cnt : mtime[63:32];
        4'h8: data_i = mtimecmp[31:0];
        4'hC: data_i = noise_en ? 32'hA5A5_0000 + noise_cnt : mtimecmp[63:32];
        default: data_i = 32'h0;
      endcase
    end
  end

  always @(posedge clk_i) begin
    if (!(!csb_o && !wen_o && !addr_o[3])) mtime <= mtime + 64'd1;
    if (!csb_o && !wen_o) begin
      case (addr_o)
        4'h0: mtime[31:0]     <= merge(mtime[31:0], data_o, wmask_o);
        4'h4: mtime[63:32]    <= merge(mtime[63:32], data_o, wmask_o);
        4'h8: mtimecmp[31:0]  <= merge(mtimecmp[31:0], data_o, wmask_o);
        4'hC: mtimecmp[63:32] <= merge(mtimecmp[63:32], data_o, wmask_o);
        default: ;
      endcase
    end
    if (!csb_o && wen_o && addr_o[2] && noise_en) noise_cnt <= noise_cnt + 32'd1;
  end

  // Scoreboard
  typedef struct {
    int          cyc;
    logic        wen;
    logic [3:0]  addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } bus_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [63:0] rdata;
  } rsp_t;

  bus_t        bus_q[$];
  rsp_t        rsp_q[$];
  logic [63:0] model_rdata = 64'h0;
  int          errors = 0;
  int          checks = 0;
  logic        monitor_en = 1'b0;
  logic        spur_watch = 1'b0;
  int          last_done_cyc = 0;
  logic        last_done_err = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushBus(input int c, input logic w, input logic [3:0] a, input logic [31:0] d);
    bus_t e;
    e.cyc  = c;
    e.wen  = w;
    e.addr = a;
    e.mask = w ? 4'h0 : 4'hF;
    e.data = w ? 32'h0 : d;
    bus_q.push_back(e);
  endtask

  // Reference model: expected bus trace and result of a command accepted at
  // the end of cycle n, using the peripheral contents seen during cycle n.
  // Nothing else writes the timer, so mtime during cycle n+t is mtime + t.
  task automatic predict(input logic [1:0] op, input logic [63:0] wd, input int n);
    logic        cmp;
    logic [3:0]  base;
    logic [63:0] v;
    logic [31:0] nz, hi1, hi2, lo;
    int          t, retries;
    rsp_t        r;
    cmp  = op[0];
    base = cmp ? 4'h8 : 4'h0;
    r.err = 1'b0;
    if (op == 2'b01 || op == 2'b10) begin
      pushBus(n + 1, 1'b0, base, cmp ? 32'hFFFF_FFFF : 32'h0);
      pushBus(n + 2, 1'b0, base + 4'h4, wd[63:32]);
      pushBus(n + 3, 1'b0, base, wd[31:0]);
      t = 4;
    end else begin
      nz = noise_cnt;
      retries = 0;
      t = 1;
      v = cmp ? mtimecmp : mtime + 64'(t);
      hi1 = noise_en ? 32'hA5A5_0000 + nz : v[63:32];
      if (noise_en) nz++;
      pushBus(n + t, 1'b1, base + 4'h4, 32'h0);
      t++;
      while (1) begin
        v = cmp ? mtimecmp : mtime + 64'(t);
        lo = v[31:0];
        pushBus(n + t, 1'b1, base, 32'h0);
        t++;
        v = cmp ? mtimecmp : mtime + 64'(t);
        hi2 = noise_en ? 32'hA5A5_0000 + nz : v[63:32];
        if (noise_en) nz++;
        pushBus(n + t, 1'b1, base + 4'h4, 32'h0);
        t++;
        if (hi2 == hi1) begin
          model_rdata = {hi1, lo};
          break;
        end
        retries++;
        if (retries > RETRY_MAX) begin
          r.err = 1'b1;
          break;
        end
        hi1 = hi2;
      end
    end
    r.cyc   = n + t;
    r.rdata = model_rdata;
    rsp_q.push_back(r);
  endtask

  // Monitor: pops expectations whenever the DUT drives the bus or signals done.
  initial begin : monitor
    bus_t e;
    rsp_t r;
    forever begin
      @(negedge clk_i);
      if (monitor_en) begin
        if (!csb_o) begin
          if (bus_q.size() == 0) begin
            checkOutput("unexpected_access", 64'(!csb_o), 64'h0);
          end else begin
            e = bus_q.pop_front();
            checkOutput("bus_cycle", 64'(cyc), 64'(e.cyc));
            checkOutput("bus_wen", 64'(wen_o), 64'(e.wen));
            checkOutput("bus_addr", 64'(addr_o), 64'(e.addr));
            checkOutput("bus_wmask", 64'(wmask_o), 64'(e.mask));
            checkOutput("bus_data", 64'(data_o), 64'(e.data));
            checkOutput("busy_in_access", 64'(busy_o), 64'h1);
          end
        end else begin
          checkOutput("idle_bus", {51'h0, wen_o, addr_o, wmask_o, 4'h0} | 64'(data_o),
                      {51'h0, 1'b1, 4'h0, 4'h0, 4'h0});
          if (bus_q.size() != 0 && bus_q[0].cyc <= cyc) begin
            checkOutput("missing_access", 64'(!csb_o), 64'h1);
            void'(bus_q.pop_front());
          end
        end
        if (done_o) begin
          if (rsp_q.size() == 0) begin
            checkOutput("unexpected_done", 64'(done_o), 64'h0);
          end else begin
            r = rsp_q.pop_front();
            checkOutput("done_cycle", 64'(cyc), 64'(r.cyc));
            checkOutput("done_err", 64'(err_o), 64'(r.err));
            checkOutput("done_rdata", rdata_o, r.rdata);
            checkOutput("busy_in_done", 64'(busy_o), 64'h1);
            last_done_cyc = cyc;
            last_done_err = err_o;
          end
        end else begin
          checkOutput("err_without_done", 64'(err_o), 64'h0);
          if (rsp_q.size() != 0 && rsp_q[0].cyc <= cyc) begin
            checkOutput("missing_done", 64'(done_o), 64'h1);
            void'(rsp_q.pop_front());
          end
        end
        if (spur_watch) checkOutput("mtip_spurious", 64'(mtip), 64'h0);
      end
    end
  end

  // Raises req_i (held while the DUT is busy), predicts at the acceptance
  // cycle, then drops req_i and scrambles op/wdata to prove they were latched.
  task automatic applyStimulus(input logic [1:0] op, input logic [63:0] wd, output int n);
    int budget;
    budget = 0;
    req_i   = 1'b1;
    op_i    = op;
    wdata_i = wd;
    while (busy_o !== 1'b0 && budget < 200) begin
      @(posedge clk_i); #1;
      budget++;
    end
    if (budget >= 200) checkOutput("accept_timeout", 64'(busy_o), 64'h0);
    n = cyc;
    predict(op, wd, n);
    @(posedge clk_i); #1;
    req_i   = 1'b0;
    op_i    = 2'($urandom);
    wdata_i = {$urandom, $urandom};
  endtask

  task automatic waitDrain();
    int b;
    b = 0;
    while ((busy_o !== 1'b0 || rsp_q.size() != 0) && b < 500) begin
      @(posedge clk_i); #1;
      b++;
    end
    if (b >= 500) checkOutput("drain_timeout", 64'(rsp_q.size()), 64'h0);
  endtask

  task automatic checkIdleOutputs();
    checkOutput("rst_csb", 64'(csb_o), 64'h1);
    checkOutput("rst_wen", 64'(wen_o), 64'h1);
    checkOutput("rst_addr", 64'(addr_o), 64'h0);
    checkOutput("rst_wmask", 64'(wmask_o), 64'h0);
    checkOutput("rst_data", 64'(data_o), 64'h0);
    checkOutput("rst_busy", 64'(busy_o), 64'h0);
    checkOutput("rst_done", 64'(done_o), 64'h0);
    checkOutput("rst_err", 64'(err_o), 64'h0);
    checkOutput("rst_rdata", rdata_o, 64'h0);
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n, n2;
    logic [63:0] wd;
    logic [1:0]  op;

    // Power-on reset
    repeat (3) @(posedge clk_i);
    #1;
    checkIdleOutputs();
    reset_i = 1'b1;
    monitor_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // Basic write of mtimecmp, with a request raised while busy (N+2..N+4)
    applyStimulus(2'b01, 64'h0000_0001_0000_0200, n);
    @(posedge clk_i); #1;
    req_i = 1'b1; op_i = 2'b10; wdata_i = 64'hDEAD_BEEF_0000_0000;
    repeat (3) begin @(posedge clk_i); #1; end
    req_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    waitDrain();
    checkOutput("write_latency", 64'(last_done_cyc - n), 64'd4);
    checkOutput("no_extra_sequence", 64'(busy_o), 64'h0);
    checkOutput("mtimecmp_value", mtimecmp, 64'h0000_0001_0000_0200);

    // Read-back of mtimecmp
    applyStimulus(2'b11, 64'h0, n);
    waitDrain();
    checkOutput("readback_rdata", rdata_o, 64'h0000_0001_0000_0200);

    // Reset in the middle of a write, during WR_HI
    applyStimulus(2'b10, 64'h0000_0007_0000_0007, n);
    @(posedge clk_i); #2;
    monitor_en = 1'b0;
    reset_i = 1'b0;
    #1;
    checkIdleOutputs();
    bus_q.delete();
    rsp_q.delete();
    model_rdata = 64'h0;
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    monitor_en = 1'b1;
    repeat (5) begin @(posedge clk_i); #1; end
    checkOutput("post_reset_idle", 64'(busy_o), 64'h0);

    // Wrap-around: write mtime, then a read held on req_i across the write
    applyStimulus(2'b10, 64'h0000_0001_FFFF_FFFD, n);
    applyStimulus(2'b00, 64'h0, n2);
    waitDrain();
    checkOutput("wrap_accept_cycle", 64'(n2 - n), 64'd5);
    checkOutput("wrap_latency", 64'(last_done_cyc - n2), 64'd6);
    checkOutput("wrap_rdata", rdata_o, 64'h0000_0002_0000_0002);

    // No spurious interrupt while rewriting mtimecmp below a pending value
    applyStimulus(2'b01, 64'h0000_0001_0000_0000, n);
    applyStimulus(2'b10, 64'h0000_0000_0000_0F00, n);
    waitDrain();
    spur_watch = 1'b1;
    applyStimulus(2'b01, 64'h0000_0000_0000_1000, n);
    waitDrain();
    spur_watch = 1'b0;
    n = 0;
    while (mtime < 64'h1000 && n < 1000) begin
      checkOutput("mtip_before_match", 64'(mtip), 64'h0);
      @(posedge clk_i); #1;
      n++;
    end
    checkOutput("mtime_at_rise", mtime, 64'h1000);
    checkOutput("mtip_at_match", 64'(mtip), 64'h1);

    // Retry limit: every hi read differs
    noise_en = 1'b1;
    applyStimulus(2'b00, 64'h0, n);
    waitDrain();
    noise_en = 1'b0;
    checkOutput("retry_err", 64'(last_done_err), 64'h1);
    checkOutput("retry_latency", 64'(last_done_cyc - n), 64'(2 + 2 * (RETRY_MAX + 1)));
    checkOutput("retry_rdata_kept", rdata_o, 64'h0000_0002_0000_0002);

    // Randomized commands, some of them near a low-word wrap
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      wd = {$urandom, $urandom};
      if (op == 2'b10 && $urandom_range(0, 1) == 1)
        wd[31:0] = 32'hFFFF_FFF0 + 32'($urandom_range(0, 14));
      applyStimulus(op, wd, n);
      repeat ($urandom_range(0, 4)) begin @(posedge clk_i); #1; end
    end
    waitDrain();
    repeat (3) begin @(posedge clk_i); #1; end
    checkOutput("scoreboard_empty", 64'(bus_q.size() + rsp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
